// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel memory responder: FSM states, region sizes
// and address legality helpers used by the responder and its result RAM.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_ACK  = 3'd2,
    WR_WAIT = 3'd3,
    WR_ACK  = 3'd4
  } state_e;

  localparam int IMG_PIXELS     = 1024;
  localparam int RES_WORDS      = 900;
  localparam int PIX_PER_READ   = 9;
  localparam int RD_OFF_LIMIT   = 4096;
  localparam int WR_OFF_LIMIT   = 1800;

  // Reads are word aligned into pixel space, writes are halfword aligned.
  function automatic logic rd_off_legal(input logic [31:0] off);
    return (off < 32'(RD_OFF_LIMIT)) && (off[1:0] == 2'b00);
  endfunction

  function automatic logic wr_off_legal(input logic [31:0] off);
    return (off < 32'(WR_OFF_LIMIT)) && (off[0] == 1'b0);
  endfunction

endpackage

// File: rtl/sobel_result_ram.sv
// 900 x 16 result storage: one write port from the responder, one registered
// read port for the host. A same-cycle write/read to one index returns old data.
module sobel_result_ram
  import sobel_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [9:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [9:0]  raddr_i,
  output logic [15:0] rdata_o
);

  logic [15:0] mem_q [RES_WORDS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range host indices read as zero rather than aliasing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (raddr_i < 10'(RES_WORDS)) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_mem_responder.sv
// Memory-side responder for a Sobel engine: serves 9-pixel window reads from a
// 32x32 image RAM and 16-bit result writes into a 30x30 result RAM.
module sobel_mem_responder
  import sobel_pkg::*;
#(
  parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
  parameter logic [31:0] DST_BASE   = 32'h0001_0000,
  parameter int          RD_LATENCY = 2,
  parameter int          WR_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_req,
  input  logic [31:0] mem_read_addr,
  output logic        mem_read_ack,
  output logic [71:0] mem_read_data,
  input  logic        mem_write_req,
  input  logic [31:0] mem_write_addr,
  input  logic [15:0] mem_write_data,
  output logic        mem_write_ack,
  input  logic        host_img_we,
  input  logic [9:0]  host_img_addr,
  input  logic [7:0]  host_img_wdata,
  input  logic [9:0]  host_res_addr,
  output logic [15:0] host_res_rdata,
  input  logic        err_clr,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [71:0] rd_data_q, rd_data_d;
  logic        err_q, err_d, err_set;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  logic [9:0]  rd_pix_q, rd_pix_d;
  logic        rd_legal_q, rd_legal_d;
  logic [9:0]  wr_idx_q, wr_idx_d;
  logic        wr_legal_q, wr_legal_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic [31:0] rd_off, wr_off;
  logic        res_we;
  logic [71:0] rd_pack;
  logic [10:0] pix_idx;
  logic [7:0]  pix_val;
  logic [7:0]  img_mem [IMG_PIXELS];

  // Unsigned subtraction: addresses below the base wrap high and fail the limit.
  assign rd_off = mem_read_addr - SRC_BASE;
  assign wr_off = mem_write_addr - DST_BASE;

  always_ff @(posedge clk) begin
    if (host_img_we) begin
      img_mem[host_img_addr] <= host_img_wdata;
    end
  end

  // Window gather; a host write landing on the latch edge is forwarded so the
  // acked data always reflects every write issued before the ack cycle.
  always_comb begin
    rd_pack = '0;
    pix_idx = '0;
    pix_val = '0;
    for (int k = 0; k < PIX_PER_READ; k++) begin
      pix_idx = 11'(rd_pix_q) + 11'(k);
      pix_val = 8'h00;
      if (pix_idx < 11'(IMG_PIXELS)) begin
        pix_val = img_mem[pix_idx[9:0]];
        if (host_img_we && (host_img_addr == pix_idx[9:0])) begin
          pix_val = host_img_wdata;
        end
      end
      rd_pack[71-8*k -: 8] = pix_val;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = '0;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_pix_d   = rd_pix_q;
    rd_legal_d = rd_legal_q;
    wr_idx_d   = wr_idx_q;
    wr_legal_d = wr_legal_q;
    wr_data_d  = wr_data_q;
    err_set    = 1'b0;
    res_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read_req) begin
          rd_pix_d   = rd_off[11:2];
          rd_legal_d = rd_off_legal(rd_off);
          cnt_d      = RD_LOAD;
          state_d    = RD_WAIT;
        end else if (mem_write_req) begin
          wr_idx_d   = wr_off[10:1];
          wr_legal_d = wr_off_legal(wr_off);
          wr_data_d  = mem_write_data;
          cnt_d      = WR_LOAD;
          state_d    = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RD_ACK;
          rd_data_d = rd_legal_q ? rd_pack : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_ACK: begin
        rd_data_d = rd_data_q;
        rd_cnt_d  = rd_cnt_q + 16'd1;
        err_set   = !rd_legal_q;
        state_d   = IDLE;
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_ACK: begin
        res_we   = wr_legal_q;
        wr_cnt_d = wr_cnt_q + 16'd1;
        err_set  = !wr_legal_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh error wins over a simultaneous clear.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_pix_q   <= rd_pix_d;
    rd_legal_q <= rd_legal_d;
    wr_idx_q   <= wr_idx_d;
    wr_legal_q <= wr_legal_d;
    wr_data_q  <= wr_data_d;
  end

  sobel_result_ram u_res_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (res_we),
    .waddr_i (wr_idx_q),
    .wdata_i (wr_data_q),
    .raddr_i (host_res_addr),
    .rdata_o (host_res_rdata)
  );

  assign mem_read_ack  = (state_q == RD_ACK);
  assign mem_write_ack = (state_q == WR_ACK);
  assign mem_read_data = rd_data_q;
  assign err           = err_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule
